// File: rtl/regfile_sequencer.sv
// Multi-cycle register-to-register command sequencer: reads two operands,
// runs a small ALU op and writes the result back through the single write port.
module regfile_sequencer #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 4,
    parameter int IMM_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_src2,
    input  logic [IMM_W-1:0]  cmd_imm,
    output logic [ADDR_W-1:0] rf_src1_addr,
    input  logic [DATA_W-1:0] rf_src1_data,
    output logic [ADDR_W-1:0] rf_src2_addr,
    input  logic [DATA_W-1:0] rf_src2_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_dst_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_MOV  = 3'b101;
    localparam logic [2:0] OP_LDI  = 3'b110;
    localparam logic [2:0] OP_SWAP = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_EXEC   = 3'd2,
        S_WRITE  = 3'd3,
        S_WRITE2 = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] dst_q, src1_q, src2_q;
    logic [IMM_W-1:0]  imm_q;
    logic [DATA_W-1:0] a_q, b_q, result_q;
    logic              carry_q, zero_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W:0]   alu_out;
    logic              is_swap;

    // Returns {carry, result}; the top bit is the carry-out for ADD, the
    // borrow for SUB, and the incoming carry for ops that leave it untouched.
    function automatic logic [DATA_W:0] alu(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [IMM_W-1:0]  imm,
        input logic              cin
    );
        logic [DATA_W:0] r;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {cin, a & b};
            OP_OR:   r = {cin, a | b};
            OP_XOR:  r = {cin, a ^ b};
            OP_MOV:  r = {cin, a};
            OP_LDI:  r = {cin, {(DATA_W-IMM_W){1'b0}}, imm};
            default: r = {cin, a};
        endcase
        return r;
    endfunction

    assign is_swap = (op_q == OP_SWAP);
    assign alu_out = alu(op_q, a_q, b_q, imm_q, carry_q);

    // Source fields only change on accept, which always enters READ, so the
    // latched fields already hold the last READ addresses outside of READ.
    assign rf_src1_addr = src1_q;
    assign rf_src2_addr = src2_q;

    assign result   = result_q;
    assign carry    = carry_q;
    assign zero     = zero_q;
    assign op_count = cnt_q;

    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        rf_we       = 1'b0;
        rf_dst_addr = dst_q;
        rf_wdata    = result_q;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = S_READ;
            end
            S_READ:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WRITE;
            S_WRITE: begin
                rf_we = 1'b1;
                if (is_swap) begin
                    rf_dst_addr = src1_q;
                    rf_wdata    = b_q;
                    state_nxt   = S_WRITE2;
                end else begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WRITE2: begin
                rf_we       = 1'b1;
                rf_dst_addr = src2_q;
                rf_wdata    = a_q;
                done        = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Reset overrides everything so no write can slip out while it is high.
        if (reset) begin
            cmd_ready = 1'b0;
            rf_we     = 1'b0;
            done      = 1'b0;
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            op_q     <= '0;
            dst_q    <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && cmd_valid) begin
                op_q   <= cmd_op;
                dst_q  <= cmd_dst;
                src1_q <= cmd_src1;
                src2_q <= cmd_src2;
                imm_q  <= cmd_imm;
            end
            if (state == S_READ) begin
                a_q <= rf_src1_data;
                b_q <= rf_src2_data;
            end
            if (state == S_EXEC && !is_swap) begin
                result_q <= alu_out[DATA_W-1:0];
                zero_q   <= (alu_out[DATA_W-1:0] == '0);
                if (op_q == OP_ADD || op_q == OP_SUB) carry_q <= alu_out[DATA_W];
            end
            if (done) cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench: owns a 16-entry register file, drives directed and random
// commands, and compares every cycle against a timing-level behavioural model.
module tb_regfile_sequencer;

    localparam int DATA_W = 20;
    localparam int ADDR_W = 4;
    localparam int IMM_W  = 8;
    localparam int CNT_W  = 16;
    localparam longint MOD = 64'd1048576;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_MOV  = 3'd5;
    localparam logic [2:0] OP_LDI  = 3'd6;
    localparam logic [2:0] OP_SWAP = 3'd7;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = '0;
    logic [ADDR_W-1:0] cmd_dst = '0, cmd_src1 = '0, cmd_src2 = '0;
    logic [IMM_W-1:0]  cmd_imm = '0;
    logic [ADDR_W-1:0] rf_src1_addr, rf_src2_addr, rf_dst_addr;
    logic [DATA_W-1:0] rf_src1_data, rf_src2_data, rf_wdata;
    logic              rf_we, done, carry, zero;
    logic [DATA_W-1:0] result;
    logic [CNT_W-1:0]  op_count;

    regfile_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMM_W(IMM_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_imm(cmd_imm),
        .rf_src1_addr(rf_src1_addr), .rf_src1_data(rf_src1_data),
        .rf_src2_addr(rf_src2_addr), .rf_src2_data(rf_src2_data),
        .rf_we(rf_we), .rf_dst_addr(rf_dst_addr), .rf_wdata(rf_wdata),
        .done(done), .result(result), .carry(carry), .zero(zero), .op_count(op_count)
    );

    always #5 clock = ~clock;

    // Register file driven by the DUT
    logic [DATA_W-1:0] rf [16] = '{default: '0};
    assign rf_src1_data = rf[rf_src1_addr];
    assign rf_src2_data = rf[rf_src2_addr];
    always @(posedge clock) if (rf_we) rf[rf_dst_addr] <= rf_wdata;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int acc_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Behavioural model: one outstanding command, operands taken from the
    // model register file at accept, writes scheduled relative to the accept edge.
    logic [DATA_W-1:0] mrf [16] = '{default: '0};
    bit                model_ok = 0;
    bit                pend = 0;
    int                acc_edge = 0;
    logic [2:0]        p_op;
    logic [3:0]        p_dst, p_s1, p_s2;
    logic [DATA_W-1:0] p_a, p_b, p_res;
    logic              p_carry;
    logic [DATA_W-1:0] m_result = '0;
    logic              m_carry = 1'b0, m_zero = 1'b0;
    logic [CNT_W-1:0]  m_count = '0;

    always @(negedge clock) begin : model
        int ph;
        bit ew, edn, erdy;
        logic [3:0] ea;
        logic [DATA_W-1:0] ed;
        longint a, b, s;
        ph   = pend ? cyc - acc_edge : -1;
        erdy = !reset && !pend;
        ew = 0; edn = 0; ea = '0; ed = '0;
        if (!reset && pend && ph == 2) begin
            ew = 1;
            if (p_op == OP_SWAP) begin ea = p_s1; ed = p_b; end
            else begin ea = p_dst; ed = p_res; edn = 1; end
        end
        if (!reset && pend && ph == 3) begin
            ew = 1; ea = p_s2; ed = p_a; edn = 1;
        end
        if (model_ok) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(erdy));
            chk("rf_we", 32'(rf_we), 32'(ew));
            chk("done", 32'(done), 32'(edn));
            if (ew) begin
                chk("rf_dst_addr", 32'(rf_dst_addr), 32'(ea));
                chk("rf_wdata", 32'(rf_wdata), 32'(ed));
            end
            if (pend && ph == 0) begin
                chk("rf_src1_addr", 32'(rf_src1_addr), 32'(p_s1));
                chk("rf_src2_addr", 32'(rf_src2_addr), 32'(p_s2));
            end
            chk("result", 32'(result), 32'(m_result));
            chk("carry", 32'(carry), 32'(m_carry));
            chk("zero", 32'(zero), 32'(m_zero));
            chk("op_count", 32'(op_count), 32'(m_count));
        end
        if (reset) begin
            pend = 0; m_result = '0; m_carry = 0; m_zero = 0; m_count = '0;
            model_ok = 1;
        end else if (model_ok) begin
            if (pend && ph == 1 && p_op != OP_SWAP) begin
                m_result = p_res;
                m_zero   = (p_res == 0);
                if (p_op == OP_ADD || p_op == OP_SUB) m_carry = p_carry;
            end
            if (ew) mrf[ea] = ed;
            if (edn) begin m_count = m_count + 1'b1; pend = 0; end
            if (erdy && cmd_valid) begin
                pend = 1; acc_edge = cyc + 1; acc_cnt++;
                p_op = cmd_op; p_dst = cmd_dst; p_s1 = cmd_src1; p_s2 = cmd_src2;
                p_a = mrf[cmd_src1]; p_b = mrf[cmd_src2];
                a = longint'(p_a); b = longint'(p_b);
                p_carry = 0; p_res = '0;
                case (cmd_op)
                    OP_ADD: begin s = a + b; p_carry = (s >= MOD); p_res = DATA_W'(s % MOD); end
                    OP_SUB: begin p_carry = (a < b); p_res = DATA_W'(a - b + (a < b ? MOD : 0)); end
                    OP_AND: p_res = p_a & p_b;
                    OP_OR:  p_res = p_a | p_b;
                    OP_XOR: p_res = p_a ^ p_b;
                    OP_MOV: p_res = p_a;
                    OP_LDI: p_res = DATA_W'(cmd_imm);
                    default: p_res = '0;
                endcase
            end
        end
    end

    // Present a command and hold it until the model sees it accepted;
    // returns just after the accept edge with cmd_valid still high.
    task automatic issue(input logic [2:0] op, input int d, input int s1, input int s2, input int imm);
        int start;
        bit ok;
        cmd_valid = 1; cmd_op = op;
        cmd_dst = ADDR_W'(d); cmd_src1 = ADDR_W'(s1); cmd_src2 = ADDR_W'(s2); cmd_imm = IMM_W'(imm);
        start = acc_cnt; ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            if (acc_cnt != start) begin ok = 1; break; end
        end
        #1;
        chk("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic finish_cmd();
        bit ok;
        cmd_valid = 0; ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            if (!pend) begin ok = 1; break; end
        end
        #1;
        chk("complete_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        // Reset for two cycles
        reset = 1;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        @(posedge clock); #1;

        issue(OP_LDI, 1, 0, 0, 8'h5A); finish_cmd();
        issue(OP_LDI, 2, 0, 0, 8'h0F); finish_cmd();
        issue(OP_ADD, 3, 1, 2, 0);     finish_cmd();
        @(negedge clock);
        chk("add_r3", 32'(rf[3]), 32'h00069);
        chk("add_carry", 32'(carry), 32'd0);
        chk("add_zero", 32'(zero), 32'd0);
        chk("add_count", 32'(op_count), 32'd3);

        issue(OP_SUB, 4, 0, 1, 0); finish_cmd();
        @(negedge clock);
        chk("sub_r4", 32'(rf[4]), 32'hFFFA6);
        chk("sub_borrow", 32'(carry), 32'd1);
        issue(OP_ADD, 5, 4, 1, 0); finish_cmd();
        @(negedge clock);
        chk("wrap_r5", 32'(rf[5]), 32'h00000);
        chk("wrap_carry", 32'(carry), 32'd1);
        chk("wrap_zero", 32'(zero), 32'd1);

        issue(OP_SWAP, 0, 1, 2, 0); finish_cmd();
        @(negedge clock);
        chk("swap_r1", 32'(rf[1]), 32'h0000F);
        chk("swap_r2", 32'(rf[2]), 32'h0005A);
        chk("swap_result", 32'(result), 32'd0);
        chk("swap_zero", 32'(zero), 32'd1);

        // Back-to-back with cmd_valid held high throughout
        issue(OP_LDI, 7, 0, 0, 8'h11);
        issue(OP_ADD, 8, 1, 2, 0);
        issue(OP_XOR, 9, 8, 7, 0);
        issue(OP_OR, 10, 7, 1, 0);
        finish_cmd();
        @(negedge clock);
        chk("b2b_count", 32'(op_count), 32'd10);
        chk("b2b_r9", 32'(rf[9]), 32'h00078);

        // Abort during EXEC
        issue(OP_ADD, 3, 2, 2, 0);
        cmd_valid = 0;
        @(posedge clock); #1 reset = 1;
        @(posedge clock); #1 reset = 0;
        @(negedge clock);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_count", 32'(op_count), 32'd0);
        @(posedge clock); #1;
        issue(OP_MOV, 6, 3, 0, 0); finish_cmd();
        @(negedge clock);
        chk("abort_r6", 32'(rf[6]), 32'h00069);
        @(posedge clock); #1;

        // Randomized traffic with occasional aborts
        for (int n = 0; n < 60; n++) begin
            issue(3'($urandom_range(7)), $urandom_range(15), $urandom_range(15),
                  $urandom_range(15), $urandom_range(255));
            if ($urandom_range(9) == 0) begin
                cmd_valid = 0;
                repeat ($urandom_range(4)) @(posedge clock);
                #1 reset = 1;
                @(posedge clock); #1 reset = 0;
            end else if ($urandom_range(1) == 0) begin
                cmd_valid = 0;
                repeat ($urandom_range(3)) @(posedge clock);
                #1;
            end
        end
        finish_cmd();
        for (int r = 0; r < 16; r++) chk("final_rf", 32'(rf[r]), 32'(mrf[r]));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Multi-cycle command sequencer that owns both read ports and the write port of the 16 x 20-bit register file.
- Accepts one register-to-register command per valid/ready handshake, reads the operands, executes a simple ALU op and writes the result back.
- Sits between the instruction/control path and the register file. It is the only agent driving the register-file write port.

Parameters:
- DATA_W, 20, register/data width.
- ADDR_W, 4, register address width (16 registers).
- IMM_W, 8, immediate width for LDI; zero-extended to DATA_W.
- CNT_W, 16, completed-command counter width.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MOV, 110 LDI, 111 SWAP.
- cmd_dst  in  ADDR_W  destination register.
- cmd_src1  in  ADDR_W  operand A register.
- cmd_src2  in  ADDR_W  operand B register.
- cmd_imm  in  IMM_W  immediate for LDI.
- rf_src1_addr  out  ADDR_W  register file read port 1 address.
- rf_src1_data  in  DATA_W  register file read port 1 data (combinational).
- rf_src2_addr  out  ADDR_W  read port 2 address.
- rf_src2_data  in  DATA_W  read port 2 data.
- rf_we  out  1  register file write enable.
- rf_dst_addr  out  ADDR_W  write address.
- rf_wdata  out  DATA_W  write data.
- done  out  1  one-cycle pulse on the final write cycle of a command.
- result  out  DATA_W  last computed result; holds until the next EXEC.
- carry  out  1  ADD carry-out / SUB borrow of the last arithmetic op.
- zero  out  1  result==0 for the last non-SWAP op.
- op_count  out  CNT_W  completed commands, wraps modulo 2^CNT_W.

Behaviour:
- Reset values:
  - state IDLE.
  - result=0, carry=0, zero=0, op_count=0, done=0.
  - Latched command fields and operands A/B = 0.
- Reset does not clear register file contents.
- rf_we is gated by !reset, so no write can occur in a cycle where reset is high.
- States: IDLE, READ, EXEC, WRITE, WRITE2.
- cmd_ready = (state==IDLE) && !reset, decoded combinationally.
- A command is accepted on the edge where cmd_valid && cmd_ready. At that edge op/dst/src1/src2/imm are latched and state goes to READ.
- READ:
  - rf_src1_addr = src1, rf_src2_addr = src2.
  - A <= rf_src1_data and B <= rf_src2_data at the end of the cycle.
  - Next state is EXEC.
  - Outside READ, the read addresses hold their last values.
- EXEC: compute the result with a 21-bit internal sum.
  - ADD: {carry,result} = A+B.
  - SUB: {carry,result} = A-B; carry=1 means borrow (A<B).
  - AND/OR/XOR/MOV(=A)/LDI(=zero-extended imm): result computed, carry unchanged.
  - zero <= (new result==0) for all ops except SWAP.
  - SWAP leaves result, carry and zero unchanged.
  - Next state is WRITE.
- WRITE:
  - Non-SWAP: rf_we=1, rf_dst_addr=dst, rf_wdata=result, done=1, op_count+1, then IDLE.
  - SWAP: rf_we=1, rf_dst_addr=src1, rf_wdata=B, then WRITE2.
- WRITE2 (SWAP only): rf_we=1, rf_dst_addr=src2, rf_wdata=A, done=1, op_count+1, then IDLE.
- Latency and throughput, with accept at edge N:
  - Non-SWAP: write and done occur in the cycle between edges N+2 and N+3. cmd_ready is high again after edge N+3, giving 4 cycles per command.
  - SWAP: the second write and done occur one cycle later, giving 5 cycles per command.
- Operands are latched before write-back, so dst equal to a source, and SWAP with src1==src2, behave correctly. SWAP with src1==src2 performs two identical writes.
- rf_we is 0 in IDLE, READ and EXEC.
- cmd_valid held high while busy is ignored. No command is dropped or double-accepted.
- Reset mid-command: the command is aborted and no further writes occur. A write already completed (SWAP first half) is not undone. Next cycle the state is IDLE with cmd_ready=1.
- op_count wraps from 0xFFFF to 0.

Test Plan:
1. Assert reset 2 cycles, then release -> cmd_ready=1, rf_we=0, done=0, result=0, carry=0, zero=0, op_count=0.
2. LDI r1,0x5A; LDI r2,0x0F; ADD r3=r1+r2 -> third command writes r3=0x00069 exactly 3 cycles after accept, done pulse, carry=0, zero=0, op_count=3.
3. SUB r4=r0-r1 (r0=0) -> r4=0xFFFA6, carry=1. Then ADD r5=r4+r1 -> r5=0x00000, carry=1, zero=1.
4. SWAP r1,r2 -> consecutive writes r1<=0x0F then r2<=0x5A, done only on second. cmd_ready low 4 cycles after accept; result/carry/zero unchanged.
5. Hold cmd_valid high with a new command each handshake for 4 commands -> exactly 4 accepts, accepts spaced by 4 cycles (non-SWAP), op_count +4, no rf_we outside WRITE/WRITE2.
6. Issue ADD r3=r1+r2, assert reset during EXEC -> rf_we never asserts, r3 unchanged on readback via MOV, cmd_ready=1 the cycle after reset deasserts, op_count=0.
